// File: rtl/decode_hazard_ctrl.sv
// Decode-stage controller: instruction-class decode, load-use hazard stall
// sequencing and redirect flush for the 5-stage pipeline.
module decode_hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_id_inst,
  input  logic        if_id_valid,
  input  logic        ex_redirect,
  output logic        is_LUI,
  output logic        is_AUIPC,
  output logic        is_I_type,
  output logic        is_S_type,
  output logic        is_Iload_type,
  output logic        is_B_type,
  output logic        is_JAL,
  output logic        is_JALR,
  output logic        is_R_type,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        stalling
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 2;

  localparam logic [OPC_W-1:0] OPC_LUI   = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL   = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR  = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_B     = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD  = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_S     = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_I     = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_R     = 7'b0110011;

  // A single-cycle stall never leaves RUN; longer ones count down in STALL.
  localparam bit MULTI_STALL = (LOAD_LAT > 1);
  localparam logic [CNT_W-1:0] STALL_INIT = MULTI_STALL ? CNT_W'(LOAD_LAT - 2) : '0;

  typedef enum logic {RUN, STALL} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt, next_cnt;
  logic [REG_W-1:0]   ex_rd;
  logic               ex_is_load;

  logic [OPC_W-1:0]   opcode;
  logic [REG_W-1:0]   rs1, rs2, rd;
  logic               rs1_used, rs2_used, rd_written;
  logic               hazard;
  logic               unused_bits;

  assign opcode      = if_id_inst[6:0];
  assign rd          = if_id_inst[11:7];
  assign rs1         = if_id_inst[19:15];
  assign rs2         = if_id_inst[24:20];
  assign unused_bits = ^{if_id_inst[31:25], if_id_inst[14:12]};

  // One-hot class decode; invalid slot or unknown opcode decodes as NOP.
  always_comb begin
    is_LUI        = 1'b0;
    is_AUIPC      = 1'b0;
    is_I_type     = 1'b0;
    is_S_type     = 1'b0;
    is_Iload_type = 1'b0;
    is_B_type     = 1'b0;
    is_JAL        = 1'b0;
    is_JALR       = 1'b0;
    is_R_type     = 1'b0;
    if (if_id_valid) begin
      case (opcode)
        OPC_LUI:   is_LUI        = 1'b1;
        OPC_AUIPC: is_AUIPC      = 1'b1;
        OPC_JAL:   is_JAL        = 1'b1;
        OPC_JALR:  is_JALR       = 1'b1;
        OPC_B:     is_B_type     = 1'b1;
        OPC_LOAD:  is_Iload_type = 1'b1;
        OPC_S:     is_S_type     = 1'b1;
        OPC_I:     is_I_type     = 1'b1;
        OPC_R:     is_R_type     = 1'b1;
        default:   ;
      endcase
    end
  end

  assign rs1_used   = is_R_type | is_I_type | is_Iload_type | is_S_type | is_B_type | is_JALR;
  assign rs2_used   = is_R_type | is_S_type | is_B_type;
  assign rd_written = is_R_type | is_I_type | is_Iload_type | is_LUI | is_AUIPC | is_JAL | is_JALR;

  // Store data (rs2) counts too: there is no MEM-to-MEM forwarding path.
  assign hazard = ex_is_load & (ex_rd != '0) &
                  ((rs1_used & (rs1 == ex_rd)) | (rs2_used & (rs2 == ex_rd)));

  always_comb begin
    next_state   = state;
    next_cnt     = cnt;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (rst) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (hazard) begin
            id_ex_bubble = 1'b1;
            if (MULTI_STALL) begin
              next_state = STALL;
              next_cnt   = STALL_INIT;
            end
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
        end
        STALL: begin
          if (ex_redirect) begin
            pc_we        = 1'b1;
            if_id_we     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            next_state   = RUN;
            next_cnt     = '0;
          end else begin
            id_ex_bubble = 1'b1;
            if (cnt == '0) next_state = RUN;
            else           next_cnt   = cnt - CNT_W'(1);
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // State, stall counter and the record of the instruction entering EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      cnt        <= '0;
      ex_rd      <= '0;
      ex_is_load <= 1'b0;
      stalling   <= 1'b0;
    end else begin
      state    <= next_state;
      cnt      <= next_cnt;
      stalling <= (next_state == STALL);
      if (id_ex_bubble) begin
        ex_rd      <= '0;
        ex_is_load <= 1'b0;
      end else begin
        ex_rd      <= rd_written ? rd : '0;
        ex_is_load <= is_Iload_type;
      end
    end
  end

endmodule
